// File: rtl/channel_enable_if.sv
// Signal bundle for the ALT channel-enable stage: controller handshake plus the shared RAM port.
// The master side is the controller together with the RAM; the slave side is the enable stage.
`ifndef ADDRESS_BITS
`define ADDRESS_BITS 8
`endif
`ifndef DATA_BITS
`define DATA_BITS 16
`endif

interface channel_enable_if #(
    parameter int addrBits = `ADDRESS_BITS,
    parameter int dataBits = `DATA_BITS
);
    logic                enabled;
    logic                finished;
    logic [addrBits-1:0] channel;
    logic [addrBits-1:0] rxPid;
    logic                rxHadMessageInAlt;
    logic                rxHasMessageInAlt;
    logic                senderWaiting;
    logic [addrBits-1:0] address;
    logic                readWriteMode;
    logic [dataBits-1:0] dataIn;
    logic [dataBits-1:0] dataOut;

    modport master (
        output enabled, channel, rxPid, rxHadMessageInAlt, dataOut,
        input  finished, rxHasMessageInAlt, senderWaiting, address, readWriteMode, dataIn
    );

    modport slave (
        input  enabled, channel, rxPid, rxHadMessageInAlt, dataOut,
        output finished, rxHasMessageInAlt, senderWaiting, address, readWriteMode, dataIn
    );
endinterface

// File: rtl/channel_enable.sv
// ALT enable stage: atomically inspects one channel word, registers the receiver as an ALT
// waiter when the channel is empty, or reports a ready guard when a sender is parked.
`ifndef ADDRESS_BITS
`define ADDRESS_BITS 8
`endif
`ifndef DATA_BITS
`define DATA_BITS 16
`endif

module channel_enable #(
    parameter int addrBits = `ADDRESS_BITS,
    parameter int dataBits = `DATA_BITS
) (
    input logic             clk,
    input logic             reset,
    channel_enable_if.slave bus
);
    typedef enum logic [2:0] {IDLE, READ_REQ, READ_WAIT, WRITE, DONE} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [addrBits-1:0] chan_q;
    logic [addrBits-1:0] pid_q;
    logic                had_q;
    logic                has_q;
    logic                sender_q;
    logic                has_nxt;
    logic                sender_nxt;
    logic                latch;
    logic [dataBits-1:0] pid_word;

    // A registered PID is the zero-extended receiver PID; any upper bits make it a sender.
    assign pid_word = dataBits'(pid_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt          = state;
        has_nxt            = has_q;
        sender_nxt         = sender_q;
        latch              = 1'b0;
        bus.finished       = 1'b0;
        bus.address        = '0;
        bus.readWriteMode  = 1'b0;
        bus.dataIn         = '0;
        unique case (state)
            IDLE: begin
                if (bus.enabled) begin
                    latch      = 1'b1;
                    sender_nxt = 1'b0;
                    state_nxt  = READ_REQ;
                end
            end
            READ_REQ: begin
                bus.address = chan_q;
                state_nxt   = READ_WAIT;
            end
            READ_WAIT: begin
                if (bus.dataOut == '0) begin
                    state_nxt = WRITE;
                end else if (bus.dataOut == pid_word) begin
                    has_nxt   = had_q;
                    state_nxt = DONE;
                end else begin
                    has_nxt    = 1'b1;
                    sender_nxt = 1'b1;
                    state_nxt  = DONE;
                end
            end
            WRITE: begin
                // The write commits at the edge leaving this state, so an async reset here aborts it.
                bus.address       = chan_q;
                bus.readWriteMode = 1'b1;
                bus.dataIn        = pid_word;
                has_nxt           = had_q;
                state_nxt         = DONE;
            end
            DONE: begin
                bus.finished = 1'b1;
                if (!bus.enabled) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            has_q    <= 1'b0;
            sender_q <= 1'b0;
        end else begin
            has_q    <= has_nxt;
            sender_q <= sender_nxt;
        end
    end

    // Operands are captured once in IDLE; outputs only expose them outside IDLE.
    always_ff @(posedge clk) begin
        if (latch) begin
            chan_q <= bus.channel;
            pid_q  <= bus.rxPid;
            had_q  <= bus.rxHadMessageInAlt;
        end
    end

    assign bus.rxHasMessageInAlt = has_q;
    assign bus.senderWaiting     = sender_q;
endmodule

// File: tb/tb_channel_enable.sv
// Self-checking bench for channel_enable: directed vector table, multi-cycle corner sequences
// and randomized operations compared against a rule-level reference model.
`timescale 1ns/1ps
module tb_channel_enable;
    localparam int AW = 8;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    channel_enable_if #(.addrBits(AW), .dataBits(DW)) bus();
    channel_enable #(.addrBits(AW), .dataBits(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Shared RAM: synchronous read, write on the edge when readWriteMode is high.
    logic [DW-1:0] ram [0:255];
    logic [DW-1:0] rd_q;
    logic          poke_en = 1'b0;
    logic [AW-1:0] poke_addr = '0;
    logic [DW-1:0] poke_data = '0;
    int            wr_cnt = 0;

    always @(posedge clk) begin
        if (poke_en) begin
            ram[poke_addr] <= poke_data;
        end else if (bus.readWriteMode) begin
            ram[bus.address] <= bus.dataIn;
            wr_cnt <= wr_cnt + 1;
        end
        rd_q <= ram[bus.address];
    end
    assign bus.dataOut = rd_q;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        @(posedge clk); #1;
        poke_en = 1'b0;
    endtask

    // Starts an operation and waits (bounded) for finished; lat counts edges after the sampling edge.
    task automatic run_op(input logic [AW-1:0] ch, input logic [AW-1:0] pid, input logic had,
                          output int lat, output int writes);
        int w0;
        w0 = wr_cnt;
        bus.channel = ch; bus.rxPid = pid; bus.rxHadMessageInAlt = had; bus.enabled = 1'b1;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (bus.finished) begin
                lat = i - 1;
                break;
            end
        end
        writes = wr_cnt - w0;
    endtask

    task automatic finish_op();
        bus.enabled = 1'b0;
        @(posedge clk); #1;
        check("finished_fall", 32'(bus.finished), 32'd0);
    endtask

    // Reference: channel-word rules applied directly to the word value.
    function automatic void ref_model(input logic [DW-1:0] word, input logic [AW-1:0] pid,
                                      input logic had, output logic [DW-1:0] nw,
                                      output logic has, output logic snd, output int lat);
        if (word == '0) begin
            nw = DW'(pid); has = had; snd = 1'b0; lat = 3;
        end else if (word == DW'(pid)) begin
            nw = word; has = had; snd = 1'b0; lat = 2;
        end else begin
            nw = word; has = 1'b1; snd = 1'b1; lat = 2;
        end
    endfunction

    typedef struct {
        logic [AW-1:0] ch;
        logic [AW-1:0] pid;
        logic          had;
        logic [DW-1:0] word;
        logic [DW-1:0] msg;
        logic [DW-1:0] exp_word;
        logic          exp_has;
        logic          exp_sender;
        int            exp_lat;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int writes;
        logic [AW-1:0] ch;
        logic [AW-1:0] pid;
        logic [AW-1:0] x;
        logic          had;
        logic [DW-1:0] word;
        logic [DW-1:0] msg;
        logic [DW-1:0] e_word;
        logic          e_has;
        logic          e_snd;
        int            e_lat;
        logic          d_sender;
        logic          d_deliv;

        bus.enabled = 1'b0; bus.channel = '0; bus.rxPid = '0; bus.rxHadMessageInAlt = 1'b0;

        tbl[0] = '{8'd2,   8'd7,   1'b0, 16'h0000, 16'h0000, 16'h0007, 1'b0, 1'b0, 3};
        tbl[1] = '{8'd8,   8'd3,   1'b0, 16'h0008, 16'd42,   16'h0008, 1'b1, 1'b1, 2};
        tbl[2] = '{8'd10,  8'd12,  1'b1, 16'h0000, 16'h0000, 16'h000c, 1'b1, 1'b0, 3};
        tbl[3] = '{8'd10,  8'd12,  1'b0, 16'h000c, 16'h0000, 16'h000c, 1'b0, 1'b0, 2};
        tbl[4] = '{8'd20,  8'd7,   1'b0, 16'h0107, 16'hbeef, 16'h0107, 1'b1, 1'b1, 2};
        tbl[5] = '{8'd30,  8'd9,   1'b1, 16'h0009, 16'h0001, 16'h0009, 1'b1, 1'b0, 2};
        tbl[6] = '{8'd255, 8'd200, 1'b0, 16'h0000, 16'h1234, 16'h00c8, 1'b0, 1'b0, 3};
        tbl[7] = '{8'd40,  8'd1,   1'b0, 16'hffff, 16'h0005, 16'hffff, 1'b1, 1'b1, 2};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_finished", 32'(bus.finished), 32'd0);
        check("rst_has", 32'(bus.rxHasMessageInAlt), 32'd0);
        check("rst_sender", 32'(bus.senderWaiting), 32'd0);
        check("rst_address", 32'(bus.address), 32'd0);
        check("rst_rw", 32'(bus.readWriteMode), 32'd0);
        check("rst_datain", 32'(bus.dataIn), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Directed vector table
        for (int v = 0; v < 8; v++) begin
            poke(tbl[v].ch, tbl[v].word);
            poke(tbl[v].ch + 8'd1, tbl[v].msg);
            run_op(tbl[v].ch, tbl[v].pid, tbl[v].had, lat, writes);
            check($sformatf("tbl%0d_latency", v), 32'(lat), 32'(tbl[v].exp_lat));
            check($sformatf("tbl%0d_has", v), 32'(bus.rxHasMessageInAlt), 32'(tbl[v].exp_has));
            check($sformatf("tbl%0d_sender", v), 32'(bus.senderWaiting), 32'(tbl[v].exp_sender));
            check($sformatf("tbl%0d_word", v), 32'(ram[tbl[v].ch]), 32'(tbl[v].exp_word));
            check($sformatf("tbl%0d_msg", v), 32'(ram[tbl[v].ch + 8'd1]), 32'(tbl[v].msg));
            check($sformatf("tbl%0d_writes", v), 32'(writes), (tbl[v].exp_lat == 3) ? 32'd1 : 32'd0);
            @(posedge clk); #1;
            check($sformatf("tbl%0d_hold_finished", v), 32'(bus.finished), 32'd1);
            check($sformatf("tbl%0d_hold_has", v), 32'(bus.rxHasMessageInAlt), 32'(tbl[v].exp_has));
            finish_op();
        end

        // Round trip with a bench-level disable stage
        poke(8'd2, 16'h0000);
        run_op(8'd2, 8'd7, 1'b0, lat, writes);
        check("rt_registered", 32'(ram[2]), 32'd7);
        finish_op();
        if (ram[2] == 16'd7) begin
            poke(8'd2, 16'h0000);
            d_sender = 1'b0; d_deliv = 1'b0;
        end else begin
            d_sender = (ram[2] != 16'd0); d_deliv = d_sender;
        end
        check("rt_cleared", 32'(ram[2]), 32'd0);
        check("rt_no_sender", 32'(d_sender), 32'd0);
        check("rt_no_message", 32'(d_deliv), 32'd0);

        // enabled dropped and inputs changed mid-operation
        poke(8'd50, 16'h0000);
        poke(8'd51, 16'h0077);
        poke(8'd99, 16'h4444);
        bus.channel = 8'd50; bus.rxPid = 8'd33; bus.rxHadMessageInAlt = 1'b0; bus.enabled = 1'b1;
        @(posedge clk); #1;
        bus.enabled = 1'b0; bus.channel = 8'd99; bus.rxPid = 8'd1; bus.rxHadMessageInAlt = 1'b1;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (bus.finished) begin
                lat = i;
                break;
            end
        end
        check("drop_latency", 32'(lat), 32'd3);
        check("drop_word", 32'(ram[50]), 32'd33);
        check("drop_other_word", 32'(ram[99]), 32'h4444);
        check("drop_msg", 32'(ram[51]), 32'h0077);
        check("drop_has", 32'(bus.rxHasMessageInAlt), 32'd0);
        @(posedge clk); #1;
        check("drop_finished_fall", 32'(bus.finished), 32'd0);

        // Reset asserted during WRITE
        poke(8'd4, 16'h0000);
        poke(8'd5, 16'h0055);
        bus.channel = 8'd4; bus.rxPid = 8'd5; bus.rxHadMessageInAlt = 1'b1; bus.enabled = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("wr_rw", 32'(bus.readWriteMode), 32'd1);
        check("wr_address", 32'(bus.address), 32'd4);
        check("wr_datain", 32'(bus.dataIn), 32'd5);
        reset = 1'b0;
        #1;
        check("rstw_finished", 32'(bus.finished), 32'd0);
        check("rstw_has", 32'(bus.rxHasMessageInAlt), 32'd0);
        check("rstw_sender", 32'(bus.senderWaiting), 32'd0);
        check("rstw_address", 32'(bus.address), 32'd0);
        check("rstw_rw", 32'(bus.readWriteMode), 32'd0);
        check("rstw_datain", 32'(bus.dataIn), 32'd0);
        bus.enabled = 1'b0;
        @(posedge clk); #1;
        check("rstw_no_write", 32'(ram[4]), 32'd0);
        reset = 1'b1;
        #2;
        run_op(8'd4, 8'd5, 1'b0, lat, writes);
        check("rstw_next_latency", 32'(lat), 32'd3);
        check("rstw_next_word", 32'(ram[4]), 32'd5);
        check("rstw_next_has", 32'(bus.rxHasMessageInAlt), 32'd0);
        check("rstw_next_msg", 32'(ram[5]), 32'h0055);
        finish_op();

        // Randomized operations against the reference model
        for (int n = 0; n < 40; n++) begin
            ch  = 8'($urandom_range(0, 254));
            pid = 8'($urandom_range(1, 255));
            had = 1'($urandom_range(0, 1));
            msg = 16'($urandom);
            case ($urandom_range(0, 3))
                0: word = 16'h0000;
                1: word = DW'(pid);
                2: begin
                    x = 8'($urandom_range(1, 255));
                    if (x == pid) x = x + 8'd1;
                    if (x == 8'd0) x = 8'd1;
                    word = DW'(x);
                end
                default: word = {8'($urandom_range(1, 255)), pid};
            endcase
            ref_model(word, pid, had, e_word, e_has, e_snd, e_lat);
            poke(ch, word);
            poke(ch + 8'd1, msg);
            run_op(ch, pid, had, lat, writes);
            check($sformatf("rnd%0d_latency", n), 32'(lat), 32'(e_lat));
            check($sformatf("rnd%0d_has", n), 32'(bus.rxHasMessageInAlt), 32'(e_has));
            check($sformatf("rnd%0d_sender", n), 32'(bus.senderWaiting), 32'(e_snd));
            check($sformatf("rnd%0d_word", n), 32'(ram[ch]), 32'(e_word));
            check($sformatf("rnd%0d_msg", n), 32'(ram[ch + 8'd1]), 32'(msg));
            finish_op();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
